// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and constants for the RV32I pipeline
package riscv_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// rtl/ex_mem_stage_alu.sv - combinational RV32I ALU
import riscv_pipe_pkg::*;

module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  alu_op_t         ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD:  Result = SrcA + SrcB;
            ALU_SUB:  Result = SrcA - SrcB;
            ALU_AND:  Result = SrcA & SrcB;
            ALU_OR:   Result = SrcA | SrcB;
            ALU_XOR:  Result = SrcA ^ SrcB;
            ALU_SLT:  Result = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: Result = {{(XLEN-1){1'b0}}, SrcA < SrcB};
            ALU_SLL:  Result = SrcA << SrcB[4:0];
            ALU_SRL:  Result = SrcA >> SrcB[4:0];
            ALU_SRA:  Result = $unsigned($signed(SrcA) >>> SrcB[4:0]);
            default:  Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute datapath with forwarding, branch resolve and EX/MEM register
import riscv_pipe_pkg::*;

module ex_mem_stage #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [XLEN-1:0] PC_Plus4E,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            BranchE,
    input  logic [2:0]      Funct3E,
    input  logic [3:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PC_Plus4M,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            MemWriteM
);

    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero_unused;
    logic            branch_cond;

    assign fwd_a = fwd_sel_t'(ForwardAE);
    assign fwd_b = fwd_sel_t'(ForwardBE);

    // Select 11 is not a legal encoding and falls through to the register operand.
    always_comb begin
        src_a = RD1E;
        case (fwd_a)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
    end

    always_comb begin
        write_data_e = RD2E;
        case (fwd_b)
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = ALUResultM;
            default: write_data_e = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExt_E : write_data_e;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (alu_op_t'(ALUControlE)),
        .Result     (alu_result),
        .Zero       (alu_zero_unused)
    );

    // Branches always compare the two register operands, independent of ALUSrcE.
    always_comb begin
        branch_cond = 1'b0;
        case (Funct3E)
            F3_BEQ:  branch_cond = (src_a == write_data_e);
            F3_BNE:  branch_cond = (src_a != write_data_e);
            F3_BLT:  branch_cond = ($signed(src_a) <  $signed(write_data_e));
            F3_BGE:  branch_cond = ($signed(src_a) >= $signed(write_data_e));
            F3_BLTU: branch_cond = (src_a <  write_data_e);
            F3_BGEU: branch_cond = (src_a >= write_data_e);
            default: branch_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & branch_cond);
    assign PCTargetE = JalrE ? {alu_result[XLEN-1:1], 1'b0} : PCE + ImmExt_E;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResultM <= RST_VAL;
            WriteDataM <= RST_VAL;
            RdM        <= RST_VAL[4:0];
            PC_Plus4M  <= RST_VAL;
            RegWriteM  <= RST_VAL[0];
            ResultSrcM <= RST_VAL[1:0];
            MemWriteM  <= RST_VAL[0];
        end else begin
            ALUResultM <= alu_result;
            WriteDataM <= write_data_e;
            RdM        <= RdE;
            PC_Plus4M  <= PC_Plus4E;
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
        end
    end

endmodule
